seq_gen_tx: RTL and testbench
=============================

# seq_gen_tx

Serial pattern transmitter. It captures a PAT_W-bit pattern, default 10010, on a start handshake and shifts it out MSB first, one bit per clock. The pattern can repeat a programmable number of times, with programmable idle gaps between copies. The block is the stimulus/transmit end for the team's FSM serial sequence detectors and drives their single-bit data input directly.

## Interface
- PAT_W, 5: pattern length in bits (≥2)
- CNT_W, 4: width of repeat count
- GAP_W, 3: width of inter-copy gap count
- DEF_PAT, 5'b10010: pattern loaded when `pattern` is all-zero at start
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only when busy=0 and abort=0
- pattern  in  PAT_W  pattern to send; sampled on accepted start
- repeat  in  CNT_W  extra copies; total copies = repeat+1; sampled on accepted start
- gap  in  GAP_W  idle cycles between copies; sampled on accepted start
- abort  in  1  synchronous cancel of transfer in progress
- data_out  out  1  serial bit; 0 when data_vld=0
- data_vld  out  1  data_out carries a pattern bit this cycle
- busy  out  1  transfer in progress (SEND or GAP)
- done  out  1  one-cycle pulse after last bit of last copy

## Operation
- All outputs registered. Reset values: data_out=0, data_vld=0, busy=0, done=0, state=IDLE, counters 0.
- States:
  - IDLE: waits for start.
  - SEND: shifts pattern bits.
  - GAP: idles between copies.
- IDLE:
  - start=1 & abort=0 at an edge: latch the shift register (pattern, or DEF_PAT if pattern==0), rep_left=repeat, gap_len=gap, bit_cnt=PAT_W-1; go to SEND; busy=1.
- SEND:
  - Each cycle: data_vld=1, data_out=shift MSB.
  - Bit_cnt decrements each cycle.
  - On the final bit (bit_cnt==0):
    - rep_left==0: go to IDLE; assert done for the next cycle; busy=0.
    - rep_left>0, gap_len==0: reload pattern; decrement rep_left; stay in SEND. Next copy follows back-to-back with no bubble.
    - rep_left>0, gap_len>0: go to GAP with gap_cnt=gap_len-1.
- GAP:
  - data_vld=0, data_out=0, busy=1.
  - When gap_cnt==0: reload pattern, decrement rep_left, go to SEND.
- Abort:
  - In SEND or GAP: next cycle IDLE, data_vld=0, busy=0, done NOT asserted.
  - In IDLE: abort has no effect and blocks a same-cycle start.
- start while busy=1 is ignored, with no queuing.
- start in the cycle where done=1 is accepted, since the block is already in IDLE and busy=0.
- pattern/repeat/gap changes during a transfer have no effect; latched copies are used.
- Counters never wrap: bit_cnt is ⌈log2 PAT_W⌉ bits, rep_left is CNT_W, gap_cnt is GAP_W. Each counter decrements only while its value is >0 or on a defined reload.
- Reset mid-transfer: immediate return to reset values, no done.

## Timing
- Start accepted at edge N: first bit valid in cycle N+1 (edge N→N+1 output).
- Transfer length: (repeat+1)·PAT_W + repeat·gap cycles of busy=1.
- done high exactly one cycle, the cycle immediately after the final data_vld cycle.
- Abort sampled at edge M: data_vld=0 from cycle M+1.
- Max throughput: 1 bit/cycle; back-to-back transfers have 1 idle cycle (the done cycle) minimum.

## Structure
- Shared package seq_pkg:
  - state encoding constants SEQ_IDLE, SEQ_SEND, SEQ_GAP.
  - constant SEQ_PAT_10010 = 5'b10010, shared with the detector benches.
- Sub-module seq_piso: PAT_W parallel-load, MSB-first shift register with load/shift enables. The FSM and counters live in seq_gen_tx.

## Test plan
- Default pattern, one copy:
  - Stimulus: pattern=0, repeat=0, gap=0, start pulse at cycle 0.
  - Required: data_out=1,0,0,1,0 with data_vld=1 in cycles 1–5; done=1 in cycle 6 only; busy=1 in cycles 1–5.
- Back-to-back copies:
  - Stimulus: pattern=5'b10110, repeat=2, gap=0.
  - Required: 15 contiguous valid bits 10110 10110 10110; done in cycle 16.
- Copies with gap:
  - Stimulus: pattern=5'b10010, repeat=1, gap=3.
  - Required: bits in cycles 1–5; data_vld=0, data_out=0 in cycles 6–8; bits in cycles 9–13; done in cycle 14.
- Abort mid-transfer:
  - Stimulus: start as in the first scenario, abort=1 at cycle 3.
  - Required: data_vld=0 and busy=0 from cycle 4; done never asserted.
  - Also: start+abort together in IDLE → nothing sent.
- Start while busy:
  - Stimulus: start with a different pattern at cycle 2.
  - Required: ignored; original bitstream intact. A new start in the done cycle begins a new transfer the next cycle.
- Reset mid-transfer:
  - Stimulus: rst low asynchronously at cycle 3.5.
  - Required: all outputs 0 immediately; after release, IDLE and a fresh start works.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and shared pattern constants for the serial sequence blocks
package seq_pkg;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_SEND, SEQ_GAP} seq_state_e;
  localparam logic [4:0] SEQ_PAT_10010 = 5'b10010;
endpackage

// File: rtl/seq_piso.sv
// seq_piso: parallel-load MSB-first shift register with load/shift enables
module seq_piso #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr_q, sr_d;
  always_comb sr_d = load ? din : shift ? {sr_q[W-2:0], 1'b0} : sr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign msb = sr_q[W-1];
endmodule

// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serial pattern transmitter, MSB first, with repeats and inter-copy gaps
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter int               CNT_W   = 4,
  parameter int               GAP_W   = 3,
  parameter logic [PAT_W-1:0] DEF_PAT = SEQ_PAT_10010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             data_out,
  output logic             data_vld,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
  seq_state_e       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d, sel_pat, ld_pat;
  logic             dout_q, dout_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic             ld, sh, msb;
  assign sel_pat = (pattern == '0) ? DEF_PAT : pattern;
  assign ld_pat  = (state_q == SEQ_IDLE) ? sel_pat : pat_q;
  // The first bit of each copy goes straight to data_out; the register keeps the rest.
  seq_piso #(.W(PAT_W)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .shift(sh),
    .din  ({ld_pat[PAT_W-2:0], 1'b0}),
    .msb  (msb)
  );
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    dout_d    = 1'b0;
    vld_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    ld        = 1'b0;
    sh        = 1'b0;
    case (state_q)
      SEQ_IDLE: if (start && !abort) begin
        pat_d     = sel_pat;
        rep_d     = repeat_n;
        gap_len_d = gap;
        bit_cnt_d = LAST;
        state_d   = SEQ_SEND;
        ld        = 1'b1;
        dout_d    = sel_pat[PAT_W-1];
        vld_d     = 1'b1;
        busy_d    = 1'b1;
      end
      SEQ_SEND: if (abort) state_d = SEQ_IDLE;
      else if (bit_cnt_q != '0) begin
        bit_cnt_d = bit_cnt_q - 1'b1;
        sh        = 1'b1;
        dout_d    = msb;
        vld_d     = 1'b1;
        busy_d    = 1'b1;
      end else if (rep_q == '0) begin
        state_d = SEQ_IDLE;
        done_d  = 1'b1;
      end else if (gap_len_q == '0) begin
        rep_d     = rep_q - 1'b1;
        bit_cnt_d = LAST;
        ld        = 1'b1;
        dout_d    = pat_q[PAT_W-1];
        vld_d     = 1'b1;
        busy_d    = 1'b1;
      end else begin
        state_d   = SEQ_GAP;
        gap_cnt_d = gap_len_q - 1'b1;
        busy_d    = 1'b1;
      end
      SEQ_GAP: if (abort) state_d = SEQ_IDLE;
      else if (gap_cnt_q == '0) begin
        state_d   = SEQ_SEND;
        rep_d     = rep_q - 1'b1;
        bit_cnt_d = LAST;
        ld        = 1'b1;
        dout_d    = pat_q[PAT_W-1];
        vld_d     = 1'b1;
        busy_d    = 1'b1;
      end else begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        busy_d    = 1'b1;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= SEQ_IDLE;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
      dout_q    <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  assign data_out = dout_q;
  assign data_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_seq_gen_tx.sv
// tb_seq_gen_tx: directed scoreboard bench; expected {data_out,data_vld,busy,done} queued per cycle
module tb_seq_gen_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] pattern = '0;
  logic [3:0] rpt = '0;
  logic [2:0] gap = '0;
  logic       abort = 1'b0;
  logic       data_out, data_vld, busy, done;
  typedef struct {
    logic [3:0] e;
    int         n;
    string      s;
  } exp_t;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string tname = "reset";
  seq_gen_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .repeat_n(rpt),
    .gap     (gap),
    .abort   (abort),
    .data_out(data_out),
    .data_vld(data_vld),
    .busy    (busy),
    .done    (done)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if ({data_out, data_vld, busy, done} !== x.e) begin
        errors++;
        $display("FAIL %s cycle %0d {dout,vld,busy,done} got %b exp %b", x.s, x.n,
                 {data_out, data_vld, busy, done}, x.e);
      end
    end
  task automatic cy(input logic [3:0] e);
    exp_t x;
    x.e = e;
    x.n = cyc;
    x.s = tname;
    q.push_back(x);
    cyc++;
    @(posedge clk);
    #2;
  endtask
  task automatic copy(input logic [4:0] p);
    for (int i = 4; i >= 0; i--) cy({p[i], 3'b110});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cy(4'b0000);
  endtask
  task automatic go(input string nm, input logic [4:0] p, input logic [3:0] r, input logic [2:0] g);
    tname = nm;
    cyc = 0;
    pattern = p;
    rpt = r;
    gap = g;
    start = 1'b1;
    cy(4'b0000);
    start = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #2;
    idle(2);
    rst = 1'b1;
    idle(1);
    go("default", 5'b00000, 4'd0, 3'd0);
    copy(5'b10010);
    cy(4'b0001);
    idle(2);
    go("b2b", 5'b10110, 4'd2, 3'd0);
    copy(5'b10110);
    copy(5'b10110);
    copy(5'b10110);
    cy(4'b0001);
    idle(1);
    go("gap", 5'b10010, 4'd1, 3'd3);
    copy(5'b10010);
    for (int i = 0; i < 3; i++) cy(4'b0010);
    copy(5'b10010);
    cy(4'b0001);
    idle(1);
    go("abort", 5'b00000, 4'd0, 3'd0);
    cy(4'b1110);
    cy(4'b0110);
    abort = 1'b1;
    cy(4'b0110);
    abort = 1'b0;
    idle(5);
    tname = "start_abort_idle";
    cyc = 0;
    start = 1'b1;
    abort = 1'b1;
    cy(4'b0000);
    start = 1'b0;
    abort = 1'b0;
    idle(6);
    go("busy_start", 5'b00000, 4'd0, 3'd0);
    cy(4'b1110);
    start = 1'b1;
    pattern = 5'b11111;
    rpt = 4'd3;
    gap = 3'd2;
    cy(4'b0110);
    start = 1'b0;
    cy(4'b0110);
    cy(4'b1110);
    cy(4'b0110);
    tname = "done_cycle_start";
    start = 1'b1;
    pattern = 5'b10110;
    rpt = 4'd0;
    gap = 3'd0;
    cy(4'b0001);
    start = 1'b0;
    copy(5'b10110);
    cy(4'b0001);
    idle(1);
    go("reset_mid", 5'b00000, 4'd1, 3'd1);
    cy(4'b1110);
    cy(4'b0110);
    begin
      exp_t x;
      x.e = 4'b0110;
      x.n = cyc;
      x.s = tname;
      q.push_back(x);
    end
    #5;
    rst = 1'b0;
    #1;
    checks++;
    if ({data_out, data_vld, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async outputs got %b exp 0000", {data_out, data_vld, busy, done});
    end
    @(posedge clk);
    #2;
    cyc = 4;
    idle(2);
    rst = 1'b1;
    idle(3);
    go("after_reset", 5'b00000, 4'd0, 3'd0);
    copy(5'b10010);
    cy(4'b0001);
    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
